// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB3 register-bank completer.
//   ADDR_W / DATA_W      : APB address and data widths
//   IDX_W                : word-index width (paddr[7:2])
//   CNT_W                : wait-state counter width (0..15)
//   apb_state_e          : transfer FSM states
//   ID_VALUE_DEFAULT     : default read-only contents of register 0
package apb_slave_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = ADDR_W - 2;
   localparam int unsigned CNT_W  = 4;

   localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB3 bus bundle between a requester (master) and this completer (slave).
//   psel, penable, pwrite, paddr, pwdata : requester -> completer
//   prdata, pready, pslverr              : completer -> requester
interface apb_slave_regs_if;
   import apb_slave_pkg::*;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_reg_bank.sv
// Word register bank: NUM_REGS x 32 storage with one write port and a
// combinational read mux. Register 0 has no storage: it reads ID_VALUE and
// shows as zero on the flat view.
//   clk, rst_n : clock, synchronous active-low clear of regs 1..NUM_REGS-1
//   we_i       : write strobe (already qualified by the caller)
//   addr_i     : word index shared by read and write
//   wdata_i    : write data
//   rdata_o    : read data for addr_i (0 for indices with no register)
//   regs_o     : flat view, reg i at [32*i +: 32]
module apb_reg_bank
   import apb_slave_pkg::*;
#(
   parameter int unsigned       NUM_REGS = 16,
   parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we_i,
   input  logic [IDX_W-1:0]           addr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

   // Storage: reset has priority over a write on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (addr_i == IDX_W'(i)) regs_q[i] <= wdata_i;
         end
      end
   end

   // Read mux.
   always_comb begin
      rdata_o = '0;
      if (addr_i == '0) rdata_o = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (addr_i == IDX_W'(i)) rdata_o = regs_q[i];
      end
   end

   // Flat view.
   always_comb begin
      regs_o = '0;
      for (int i = 1; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
   end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer in front of a word register bank, with programmable wait
// states, error responses and protocol-violation detection.
//   pclk, preset_n : clock, synchronous active-low reset
//   apb            : APB3 bus, slave side (pready/prdata/pslverr are
//                    combinational from the access-phase state)
//   regs_o         : flat view of the bank, reg i at [32*i +: 32]
//   prot_err       : registered one-cycle pulse on a protocol violation
module apb_slave_regs
   import apb_slave_pkg::*;
#(
   parameter int unsigned       NUM_REGS    = 16,
   parameter int unsigned       WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
   input  logic                       pclk,
   input  logic                       preset_n,
   apb_slave_regs_if.slave            apb,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                       prot_err
);

   apb_state_e        state_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              prot_err_q;

   logic              access_c;
   logic              ready_c;
   logic              err_c;
   logic              we_c;
   logic              changed_c;
   logic [DATA_W-1:0] rdata_c;

   // Decode and completion, all on the values latched in the setup phase.
   assign access_c  = (state_q == ACCESS) & apb.psel & apb.penable;
   assign ready_c   = access_c & (wait_cnt_q == CNT_W'(WAIT_STATES));
   assign err_c     = (paddr_q[1:0] != 2'b00)
                    | ({1'b0, paddr_q[ADDR_W-1:2]} >= (IDX_W+1)'(NUM_REGS))
                    | (pwrite_q & (paddr_q[ADDR_W-1:2] == '0));
   assign we_c      = ready_c & pwrite_q & ~err_c;
   assign changed_c = (apb.paddr != paddr_q) | (apb.pwrite != pwrite_q)
                    | (apb.pwdata != pwdata_q);

   assign apb.pready  = ready_c;
   assign apb.pslverr = ready_c & err_c;
   assign apb.prdata  = (ready_c & ~pwrite_q & ~err_c) ? rdata_c : '0;
   assign prot_err    = prot_err_q;

   // Transfer FSM, wait counter, request latch and violation pulse.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         prot_err_q <= 1'b0;
      end else begin
         prot_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (apb.psel && !apb.penable) begin
                  paddr_q    <= apb.paddr;
                  pwrite_q   <= apb.pwrite;
                  pwdata_q   <= apb.pwdata;
                  wait_cnt_q <= '0;
                  state_q    <= ACCESS;
               end else if (apb.psel && apb.penable) begin
                  // Access phase without a setup phase: ignored.
                  prot_err_q <= 1'b1;
               end
            end
            ACCESS: begin
               if (!access_c) begin
                  // Requester gave up early: drop the transfer uncommitted.
                  state_q    <= IDLE;
                  wait_cnt_q <= '0;
                  prot_err_q <= 1'b1;
               end else begin
                  if (changed_c) prot_err_q <= 1'b1;
                  if (ready_c) begin
                     state_q    <= IDLE;
                     wait_cnt_q <= '0;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   apb_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .clk     (pclk),
      .rst_n   (preset_n),
      .we_i    (we_c),
      .addr_i  (paddr_q[ADDR_W-1:2]),
      .wdata_i (pwdata_q),
      .rdata_o (rdata_c),
      .regs_o  (regs_o)
   );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench: three completers with 0, 2 and 3 wait states share one
// requester; psel is steered to the selected one and its outputs are muxed
// back to a single monitor.
module tb_apb_slave_regs;

   localparam int          NR = 16;
   localparam logic [31:0] ID = 32'hA5B0_0001;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      int          waits;
   } exp_t;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [1:0]  sel;

   logic [31:0] prdata;
   logic        pready, pslverr, prot_err;
   logic        prot0, prot1, prot2;
   logic [NR*32-1:0] regs0, regs1, regs2;

   int   n_checks = 0;
   int   n_errors = 0;
   int   prot_cnt = 0;
   exp_t exp_q[$];
   logic [31:0] model [3][NR];

   apb_slave_regs_if bus0 ();
   apb_slave_regs_if bus1 ();
   apb_slave_regs_if bus2 ();

   assign bus0.psel = psel & (sel == 2'd0);
   assign bus1.psel = psel & (sel == 2'd1);
   assign bus2.psel = psel & (sel == 2'd2);
   assign {bus0.penable, bus0.pwrite, bus0.paddr, bus0.pwdata} = {penable, pwrite, paddr, pwdata};
   assign {bus1.penable, bus1.pwrite, bus1.paddr, bus1.pwdata} = {penable, pwrite, paddr, pwdata};
   assign {bus2.penable, bus2.pwrite, bus2.paddr, bus2.pwdata} = {penable, pwrite, paddr, pwdata};

   assign pready   = (sel == 2'd0) ? bus0.pready  : (sel == 2'd1) ? bus1.pready  : bus2.pready;
   assign pslverr  = (sel == 2'd0) ? bus0.pslverr : (sel == 2'd1) ? bus1.pslverr : bus2.pslverr;
   assign prdata   = (sel == 2'd0) ? bus0.prdata  : (sel == 2'd1) ? bus1.prdata  : bus2.prdata;
   assign prot_err = prot0 | prot1 | prot2;

   apb_slave_regs #(.NUM_REGS(NR), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
      .pclk(pclk), .preset_n(preset_n), .apb(bus0), .regs_o(regs0), .prot_err(prot0));
   apb_slave_regs #(.NUM_REGS(NR), .WAIT_STATES(2), .ID_VALUE(ID)) u_dut1 (
      .pclk(pclk), .preset_n(preset_n), .apb(bus1), .regs_o(regs1), .prot_err(prot1));
   apb_slave_regs #(.NUM_REGS(NR), .WAIT_STATES(3), .ID_VALUE(ID)) u_dut2 (
      .pclk(pclk), .preset_n(preset_n), .apb(bus2), .regs_o(regs2), .prot_err(prot2));

   always #5 pclk = ~pclk;

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   function automatic logic [NR*32-1:0] regs_of(input int k);
      return (k == 0) ? regs0 : (k == 1) ? regs1 : regs2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_regs(input int k);
      logic [NR*32-1:0] v;
      v = regs_of(k);
      for (int i = 0; i < NR; i++)
         chk($sformatf("regs_o dut%0d reg%0d", k, i), v[i*32 +: 32], model[k][i]);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NR; i++) model[k][i] = '0;
   endtask

   // Expected response from the address rules; reg 0 is ID on reads, never stored.
   function automatic exp_t predict(input int k, input bit wr, input logic [7:0] a);
      exp_t e;
      int   idx;
      bit   ok;
      idx      = int'(a) / 4;
      ok       = (int'(a) % 4 == 0) && (idx < NR) && !(wr && idx == 0);
      e.slverr = !ok;
      e.waits  = ws_of(k);
      e.rdata  = '0;
      if (!wr && ok) e.rdata = (idx == 0) ? ID : model[k][idx];
      return e;
   endfunction

   task automatic idle(input int n);
      psel    = 1'b0;
      penable = 1'b0;
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // One complete transfer; leaves psel/penable high so a setup may follow.
   task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                       input logic [31:0] d, input bit corrupt);
      int idx;
      int n;
      exp_q.push_back(predict(k, wr, a));
      idx = int'(a) / 4;
      if (wr && int'(a) % 4 == 0 && idx > 0 && idx < NR) model[k][idx] = d;
      sel = 2'(k); psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      if (corrupt) pwdata = ~d;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!pready && n < 40);
      if (!pready) begin
         n_checks++;
         n_errors++;
         $display("FAIL xfer_timeout dut%0d addr %h: pready never rose in %0d cycles", k, a, n);
      end
      @(posedge pclk); #1;
   endtask

   // Monitor: compares every completion against the oldest expectation.
   initial begin : monitor
      int   cnt;
      exp_t e;
      cnt = 0;
      forever begin
         @(negedge pclk);
         if (pready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pready: got completion with no transfer pending");
            end else begin
               e = exp_q.pop_front();
               chk("pslverr", 32'(pslverr), 32'(e.slverr));
               chk("prdata", prdata, e.rdata);
               chk("wait_cycles", 32'(cnt), 32'(e.waits));
            end
            cnt = 0;
         end else if (psel && penable && preset_n) begin
            cnt++;
         end else begin
            cnt = 0;
         end
         if (prot_err) prot_cnt++;
      end
   end

   initial begin : stim
      int          p0;
      int          k, r;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;

      clear_model();
      preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; sel = 2'd0;
      repeat (3) @(posedge pclk);
      #1 preset_n = 1'b1;

      // Reset state.
      @(negedge pclk);
      chk("reset pready", 32'(pready), 32'd0);
      chk("reset pslverr", 32'(pslverr), 32'd0);
      chk("reset prdata", prdata, 32'd0);
      chk("reset prot_err", 32'(prot_err), 32'd0);
      for (int j = 0; j < 3; j++) check_regs(j);
      @(posedge pclk); #1;
      xfer(0, 1'b0, 8'h00, '0, 1'b0);
      idle(1);

      // Two wait states: write then read back.
      xfer(1, 1'b1, 8'h0C, 32'hDEAD_BEEF, 1'b0);
      idle(1);
      xfer(1, 1'b0, 8'h0C, '0, 1'b0);
      idle(1);
      check_regs(1);

      // Error responses leave the bank alone.
      xfer(1, 1'b1, 8'h05, 32'h1111_1111, 1'b0);
      xfer(1, 1'b0, 8'h40, '0, 1'b0);
      xfer(1, 1'b1, 8'h00, 32'h2222_2222, 1'b0);
      xfer(1, 1'b0, 8'h00, '0, 1'b0);
      idle(1);
      check_regs(1);

      // Back-to-back with zero wait states.
      p0 = prot_cnt;
      xfer(0, 1'b1, 8'h04, 32'h0000_0A04, 1'b0);
      xfer(0, 1'b1, 8'h08, 32'h0000_0B08, 1'b0);
      xfer(0, 1'b1, 8'h0C, 32'h0000_0C0C, 1'b0);
      xfer(0, 1'b0, 8'h04, '0, 1'b0);
      xfer(0, 1'b0, 8'h08, '0, 1'b0);
      xfer(0, 1'b0, 8'h0C, '0, 1'b0);
      idle(2);
      chk("b2b prot_err pulses", 32'(prot_cnt - p0), 32'd0);
      check_regs(0);

      // Abort after one access cycle.
      p0 = prot_cnt;
      sel = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h1234_5678;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1;
      idle(3);
      chk("abort prot_err pulses", 32'(prot_cnt - p0), 32'd1);
      check_regs(2);
      xfer(2, 1'b1, 8'h10, 32'h8765_4321, 1'b0);
      xfer(2, 1'b0, 8'h10, '0, 1'b0);
      idle(1);
      check_regs(2);

      // Access phase with no setup phase.
      p0 = prot_cnt;
      sel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hFFFF_FFFF;
      @(posedge pclk); #1;
      idle(2);
      chk("no-setup prot_err pulses", 32'(prot_cnt - p0), 32'd1);
      check_regs(0);

      // Bus data changed mid-access: latched value wins.
      p0 = prot_cnt;
      xfer(1, 1'b1, 8'h18, 32'h5A5A_0018, 1'b1);
      idle(2);
      chk("change prot_err seen", 32'(prot_cnt > p0), 32'd1);
      xfer(1, 1'b0, 8'h18, '0, 1'b0);
      idle(1);

      // Randomized traffic across all three completers.
      p0 = prot_cnt;
      for (int t = 0; t < 80; t++) begin
         k  = int'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         if (r < 7)       a = {4'($urandom_range(0, 15)), 2'b00};
         else if (r == 7) a = {4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else if (r == 8) a = {2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 2'b00};
         else             a = 8'($urandom);
         d = $urandom;
         xfer(k, wr, a, d, 1'b0);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end
      idle(2);
      chk("random prot_err pulses", 32'(prot_cnt - p0), 32'd0);
      for (int j = 0; j < 3; j++) check_regs(j);

      // Reset on the completion edge of a write.
      exp_q.push_back(predict(0, 1'b1, 8'h14));
      sel = 2'd0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hCAFE_F00D;
      @(posedge pclk); #1;
      penable = 1'b1;
      preset_n = 1'b0;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1;
      clear_model();
      @(negedge pclk);
      chk("post-reset pready", 32'(pready), 32'd0);
      for (int j = 0; j < 3; j++) check_regs(j);
      @(posedge pclk); #1;
      xfer(0, 1'b0, 8'h14, '0, 1'b0);
      idle(2);

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
